ram_sweep_checker: RTL and testbench

Parametrised, self-sequencing multi-channel RAM exercise block. Each of NUM_CHANNELS slices owns an upper and a lower RAM bank. On request it fills both banks with a seed-derived pattern, then reads both banks back. For each slice it reports an XOR-parity signature and a sticky mismatch flag. It sits between the test harness logic and per-channel registered outputs, and replaces per-bit free-running RAM/DFF slices with a controlled sweep.

---
 rtl/ram_sweep_checker.sv | 230 +++++++++++++++++++++++
 tb/tb_ram_sweep_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sweep_checker.sv
// ram_sweep_checker
//
// Self-sequencing RAM exercise block. Each of NUM_CHANNELS slices owns an
// upper and a lower bank (DEPTH = 2^ADDR_BITS words of DATA_BITS). On an
// accepted start the block fills both banks of every slice with a
// seed-derived pattern and then reads them back. Each returned word is
// folded into a per-channel XOR-parity signature (y), and any word that
// differs from its expected value sets a sticky per-channel flag (err).
//
// Sequence: IDLE -> FILL (DEPTH cycles) -> READ (DEPTH issue cycles plus
// one drain cycle) -> DONE (one cycle) -> IDLE.
//
// Ports:
//   clk     in   sole clock, rising edge
//   rst     in   synchronous, active-high reset
//   start   in   begin a sweep; only looked at in IDLE, never queued
//   seed    in   [DATA_BITS]    pattern seed, captured on accepted start
//   inject  in   [NUM_CHANNELS] per-channel fault injection, captured on start
//   busy    out  high during FILL and READ (including the drain cycle)
//   done    out  one-cycle pulse when y/err are final
//   y       out  [NUM_CHANNELS] per-channel parity signature, registered
//   err     out  [NUM_CHANNELS] per-channel sticky mismatch flag, registered
module ram_sweep_checker #(
  parameter int NUM_CHANNELS = 1,
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_BITS-1:0]    seed,
  input  logic [NUM_CHANNELS-1:0] inject,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CHANNELS-1:0] y,
  output logic [NUM_CHANNELS-1:0] err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Address one before the last; used to raise the last-flag a cycle early.
  localparam logic [ADDR_BITS-1:0] ADDR_PENULT = ADDR_BITS'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Pattern arithmetic (all modulo 2^DATA_BITS)
  function automatic logic [DATA_BITS-1:0] widen_addr(input logic [ADDR_BITS-1:0] a);
    return DATA_BITS'(a);
  endfunction

  function automatic logic [DATA_BITS-1:0] upper_word(input logic [DATA_BITS-1:0] s,
                                                      input logic [DATA_BITS-1:0] a,
                                                      input logic [DATA_BITS-1:0] c);
    return s + a + c;
  endfunction

  function automatic logic [DATA_BITS-1:0] lower_word(input logic [DATA_BITS-1:0] s,
                                                      input logic                 inj,
                                                      input logic                 first);
    return (inj && first) ? (s ^ DATA_BITS'(1)) : s;
  endfunction

  function automatic logic [DATA_BITS-1:0] expected_word(input logic [DATA_BITS-1:0] s,
                                                         input logic [DATA_BITS-1:0] a,
                                                         input logic [DATA_BITS-1:0] c);
    return upper_word(s, a, c) ^ s;
  endfunction

  // Control and result state
  state_t                  state_q,  state_d;
  logic [ADDR_BITS-1:0]    addr_q,   addr_d;
  logic                    last_q,   last_d;
  logic                    drain_q,  drain_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [ADDR_BITS-1:0]    rd_addr_q, rd_addr_d;
  logic [DATA_BITS-1:0]    seed_q,   seed_d;
  logic [NUM_CHANNELS-1:0] inject_q, inject_d;
  logic [NUM_CHANNELS-1:0] y_q,      y_d;
  logic [NUM_CHANNELS-1:0] err_q,    err_d;
  logic                    busy_q,   busy_d;
  logic                    done_q,   done_d;

  logic                    wr_en;
  logic                    rd_en;
  logic [NUM_CHANNELS-1:0] rd_par;
  logic [NUM_CHANNELS-1:0] rd_mis;

  assign wr_en = (state_q == ST_FILL);
  assign rd_en = (state_q == ST_READ) && !drain_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    drain_d   = drain_q;
    rd_vld_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    seed_d    = seed_q;
    inject_d  = inject_q;
    y_d       = y_q;
    err_d     = err_q;

    // Fold in the word returned by the previous cycle's read.
    if (rd_vld_q) begin
      y_d   = y_q ^ rd_par;
      err_d = err_q | rd_mis;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_d   = seed;
          inject_d = inject;
          y_d      = '0;
          err_d    = '0;
          addr_d   = '0;
          last_d   = 1'b0;
          drain_d  = 1'b0;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        if (last_q) begin
          addr_d  = '0;
          last_d  = 1'b0;
          state_d = ST_READ;
        end else begin
          addr_d = addr_q + 1'b1;
          last_d = (addr_q == ADDR_PENULT);
        end
      end
      ST_READ: begin
        if (!drain_q) begin
          rd_vld_d  = 1'b1;
          rd_addr_d = addr_q;
          if (last_q) begin
            addr_d  = '0;
            last_d  = 1'b0;
            drain_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            last_d = (addr_q == ADDR_PENULT);
          end
        end else begin
          // Drain cycle: the last word is folded in above.
          drain_d = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FILL) || (state_d == ST_READ);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      last_q   <= 1'b0;
      drain_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      seed_q   <= '0;
      inject_q <= '0;
      y_q      <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      drain_q  <= drain_d;
      rd_vld_q <= rd_vld_d;
      seed_q   <= seed_d;
      inject_q <= inject_d;
      y_q      <= y_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Read address travels with the read data; it carries no reset.
  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr_d;
  end

  // Per-channel banks
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    localparam logic [DATA_BITS-1:0] CH_OFS = DATA_BITS'(c);

    logic [DATA_BITS-1:0] upper_mem [DEPTH];
    logic [DATA_BITS-1:0] lower_mem [DEPTH];
    logic [DATA_BITS-1:0] upper_rdata;
    logic [DATA_BITS-1:0] lower_rdata;
    logic [DATA_BITS-1:0] word;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        upper_mem[addr_q] <= upper_word(seed_q, widen_addr(addr_q), CH_OFS);
        lower_mem[addr_q] <= lower_word(seed_q, inject_q[c], addr_q == '0);
      end
      if (rd_en) begin
        upper_rdata <= upper_mem[addr_q];
        lower_rdata <= lower_mem[addr_q];
      end
    end

    assign word      = upper_rdata ^ lower_rdata;
    assign rd_par[c] = ^word;
    assign rd_mis[c] = (word != expected_word(seed_q, widen_addr(rd_addr_q), CH_OFS));
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;
  assign err  = err_q;

endmodule

// File: tb/tb_ram_sweep_checker.sv
module tb_ram_sweep_checker;

  localparam int NCH      = 2;
  localparam int AB       = 8;
  localparam int DB       = 16;
  localparam int DEPTH    = 1 << AB;
  localparam int DONE_CYC = 2 * DEPTH + 2;
  localparam int unsigned MASK = (32'd1 << DB) - 32'd1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [DB-1:0]  seed;
  logic [NCH-1:0] inject;
  logic           busy;
  logic           done;
  logic [NCH-1:0] y;
  logic [NCH-1:0] err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_sweep_checker #(
    .NUM_CHANNELS(NCH),
    .ADDR_BITS   (AB),
    .DATA_BITS   (DB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .seed  (seed),
    .inject(inject),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .err   (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: total popcount parity and mismatch over the whole sweep.
  function automatic void model(input logic [DB-1:0] s, input logic [NCH-1:0] inj,
                                output logic [NCH-1:0] ym, output logic [NCH-1:0] em);
    int          total;
    bit          bad;
    int unsigned upv;
    int unsigned lov;
    ym = '0;
    em = '0;
    for (int c = 0; c < NCH; c++) begin
      total = 0;
      bad   = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
        upv = (32'(s) + a + c) & MASK;
        lov = 32'(s);
        if (inj[c] && a == 0) lov = lov ^ 32'd1;
        total += $countones(upv ^ lov);
        if ((upv ^ lov) != (upv ^ 32'(s))) bad = 1'b1;
      end
      ym[c] = total[0];
      em[c] = bad;
    end
  endfunction

  // Runs one sweep. Returns sampling the done cycle (#1 after its edge),
  // or one cycle later in IDLE when start is released.
  task automatic run_sweep(input logic [DB-1:0] s, input logic [NCH-1:0] inj,
                           input bit pre_held, input bit keep_start,
                           input int pulse_at, input string tag);
    int             n;
    int             done_at;
    int             busy_bad;
    logic [NCH-1:0] ym;
    logic [NCH-1:0] em;
    if (!pre_held) begin
      @(negedge clk);
      seed   = s;
      inject = inj;
      start  = 1'b1;
    end else begin
      seed   = s;
      inject = inj;
      @(posedge clk); #1;
      check({tag, "_gap"}, 64'({busy, done}), 64'd0);
    end
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    check({tag, "_clr"}, 64'({y, err}), 64'd0);
    n        = 1;
    done_at  = -1;
    busy_bad = 0;
    while (done_at < 0 && n <= DONE_CYC + 20) begin
      if (done === 1'b1) begin
        done_at = n;
      end else begin
        if (busy !== 1'b1) busy_bad++;
        @(posedge clk); #1;
        n++;
        if (n == pulse_at) start = 1'b1;
        else if (n == pulse_at + 1) start = keep_start;
      end
    end
    check({tag, "_done_cyc"}, 64'(done_at), 64'(DONE_CYC));
    check({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    model(s, inj, ym, em);
    check({tag, "_y"}, 64'(y), 64'(ym));
    check({tag, "_err"}, 64'(err), 64'(em));
    if (!keep_start) begin
      @(posedge clk); #1;
      check({tag, "_after"}, 64'({busy, done}), 64'd0);
      check({tag, "_hold_y"}, 64'(y), 64'(ym));
    end
  endtask

  initial begin
    int bad;
    logic [DB-1:0]  rs;
    logic [NCH-1:0] ri;

    rst    = 1'b1;
    start  = 1'b0;
    seed   = '0;
    inject = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("idle_reset", 64'({busy, done, y, err}), 64'd0);
      @(posedge clk); #1;
    end

    // Defaults, seed 0, no injection
    run_sweep(16'h0000, 2'b00, 1'b0, 1'b0, -1, "s_def");
    check("s_def_y_const", 64'(y), 64'(2'b10));
    check("s_def_err_const", 64'(err), 64'(2'b00));

    // Fault injected on channel 0 only
    run_sweep(16'h0000, 2'b01, 1'b0, 1'b0, -1, "s_inj");
    check("s_inj_y_const", 64'(y), 64'(2'b11));
    check("s_inj_err_const", 64'(err), 64'(2'b01));

    // Wrapping seed
    run_sweep(16'hFFFF, 2'b00, 1'b0, 1'b0, -1, "s_ffff");
    check("s_ffff_err_const", 64'(err), 64'd0);

    // Start pulse during busy is ignored and not queued
    run_sweep(16'h1234, 2'b10, 1'b0, 1'b0, 100, "s_pulse");
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("s_pulse_no_requeue", 64'(bad), 64'd0);

    // Back-to-back with start held
    run_sweep(16'h0000, 2'b01, 1'b0, 1'b1, -1, "s_b2b_a");
    run_sweep(16'h0000, 2'b00, 1'b1, 1'b0, -1, "s_b2b_b");
    check("s_b2b_y_const", 64'(y), 64'(2'b10));

    // Reset in the middle of a sweep
    @(negedge clk);
    seed   = 16'h0000;
    inject = 2'b11;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_clear", 64'({busy, done, y, err}), 64'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("rst_mid_no_done", 64'(bad), 64'd0);
    run_sweep(16'h0000, 2'b00, 1'b0, 1'b0, -1, "s_after_rst");
    check("s_after_rst_y_const", 64'(y), 64'(2'b10));
    check("s_after_rst_err_const", 64'(err), 64'(2'b00));

    // Randomized sweeps
    for (int r = 0; r < 3; r++) begin
      rs = 16'($urandom_range(0, 65535));
      ri = 2'($urandom_range(0, 3));
      run_sweep(rs, ri, 1'b0, 1'b0, -1, "s_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
